// File: rtl/pwm_ramp_if.sv
// pwm_ramp_if: run request/estop inputs and generator drive outputs of the ramp sequencer
interface pwm_ramp_if #(parameter int SPEED_W = 3);
  logic               enable_in;
  logic [SPEED_W-1:0] target_in;
  logic               estop;
  logic               pwm_en;
  logic [SPEED_W-1:0] speed_out;
  logic               at_target;
  logic               busy;
  logic               fault;
  modport master (output enable_in, target_in, estop, input pwm_en, speed_out, at_target, busy, fault);
  modport slave  (input enable_in, target_in, estop, output pwm_en, speed_out, at_target, busy, fault);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: soft-start/soft-stop speed sequencer with latching emergency stop
module pwm_ramp_ctrl #(
  parameter int SPEED_W  = 3,
  parameter int STEP_DIV = 1000
) (
  input logic       clk,
  input logic       rst_n,
  pwm_ramp_if.slave bus
);
  localparam int CW = $clog2(STEP_DIV);
  typedef enum logic [1:0] {IDLE, RAMP, HOLD, FAULT} state_t;
  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [SPEED_W-1:0] r_speed, w_speed_nxt, w_eff_tgt;
  logic               r_pwm_en, w_pwm_en_nxt, r_at_target, r_busy, r_fault, w_tick;
  assign w_eff_tgt = bus.enable_in ? bus.target_in : '0;
  assign w_tick    = r_cnt == CW'(STEP_DIV - 1);
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_speed_nxt  = r_speed;
    w_pwm_en_nxt = r_pwm_en;
    if (bus.estop) begin
      w_state_nxt  = FAULT;
      w_speed_nxt  = '0;
      w_pwm_en_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_speed_nxt  = '0;
          w_pwm_en_nxt = w_eff_tgt != '0;
          w_state_nxt  = w_eff_tgt != '0 ? RAMP : IDLE;
        end
        // Arrival is judged on the registered speed, so a tick never steps past the target
        RAMP: begin
          if (r_speed == w_eff_tgt) begin
            w_state_nxt  = w_eff_tgt != '0 ? HOLD : IDLE;
            w_pwm_en_nxt = w_eff_tgt != '0;
          end else begin
            w_cnt_nxt   = w_tick ? '0 : r_cnt + 1'b1;
            w_speed_nxt = !w_tick ? r_speed : w_eff_tgt > r_speed ? r_speed + 1'b1 : r_speed - 1'b1;
          end
        end
        HOLD: w_state_nxt = w_eff_tgt != r_speed ? RAMP : HOLD;
        FAULT: begin
          w_speed_nxt  = '0;
          w_pwm_en_nxt = 1'b0;
          w_state_nxt  = bus.enable_in ? FAULT : IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_speed     <= '0;
      r_pwm_en    <= 1'b0;
      r_at_target <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_speed     <= w_speed_nxt;
      r_pwm_en    <= w_pwm_en_nxt;
      r_at_target <= w_state_nxt == HOLD;
      r_busy      <= w_state_nxt == RAMP;
      r_fault     <= w_state_nxt == FAULT;
    end
  end
  assign bus.pwm_en    = r_pwm_en;
  assign bus.speed_out = r_speed;
  assign bus.at_target = r_at_target;
  assign bus.busy      = r_busy;
  assign bus.fault     = r_fault;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed vector table plus reset/async-reset sequences, STEP_DIV=4
module tb_pwm_ramp_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  typedef struct {
    logic       en;
    logic [2:0] tgt;
    logic       es;
    int         n;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];
  pwm_ramp_if #(.SPEED_W(3)) bus ();
  pwm_ramp_ctrl #(.SPEED_W(3), .STEP_DIV(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic void add(logic en, logic [2:0] tgt, logic es, int n,
                              logic pwm, logic [2:0] spd, logic at, logic bsy, logic flt);
    vec_t v;
    v.en = en; v.tgt = tgt; v.es = es; v.n = n;
    v.exp = {pwm, spd, at, bsy, flt};
    tbl.push_back(v);
  endfunction
  task automatic check(string name, logic [6:0] exp);
    logic [6:0] act;
    act = {bus.pwm_en, bus.speed_out, bus.at_target, bus.busy, bus.fault};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pwm/spd/at/busy/fault=%b/%0d/%b/%b/%b expected %b/%0d/%b/%b/%b",
               name, act[6], act[5:3], act[2], act[1], act[0], exp[6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask
  initial begin
    //   en tgt es  n  pwm spd at busy flt
    add(1, 5, 0, 1,  1, 0, 0, 1, 0);
    add(1, 5, 0, 3,  1, 0, 0, 1, 0);
    add(1, 5, 0, 1,  1, 1, 0, 1, 0);
    add(1, 5, 0, 4,  1, 2, 0, 1, 0);
    add(1, 5, 0, 4,  1, 3, 0, 1, 0);
    add(1, 5, 0, 4,  1, 4, 0, 1, 0);
    add(1, 5, 0, 4,  1, 5, 0, 1, 0);
    add(1, 5, 0, 1,  1, 5, 1, 0, 0);
    add(1, 5, 0, 3,  1, 5, 1, 0, 0);
    add(1, 2, 0, 1,  1, 5, 0, 1, 0);
    add(1, 2, 0, 4,  1, 4, 0, 1, 0);
    add(1, 2, 0, 4,  1, 3, 0, 1, 0);
    add(1, 2, 0, 4,  1, 2, 0, 1, 0);
    add(1, 2, 0, 1,  1, 2, 1, 0, 0);
    add(1, 3, 0, 1,  1, 2, 0, 1, 0);
    add(1, 3, 0, 2,  1, 2, 0, 1, 0);
    add(1, 6, 0, 2,  1, 3, 0, 1, 0);
    add(1, 6, 0, 4,  1, 4, 0, 1, 0);
    add(1, 1, 0, 2,  1, 4, 0, 1, 0);
    add(1, 1, 0, 2,  1, 3, 0, 1, 0);
    add(1, 3, 0, 1,  1, 3, 1, 0, 0);
    add(0, 3, 0, 1,  1, 3, 0, 1, 0);
    add(0, 3, 0, 4,  1, 2, 0, 1, 0);
    add(0, 3, 0, 4,  1, 1, 0, 1, 0);
    add(0, 3, 0, 4,  1, 0, 0, 1, 0);
    add(0, 3, 0, 1,  0, 0, 0, 0, 0);
    add(1, 1, 0, 1,  1, 0, 0, 1, 0);
    add(1, 1, 0, 4,  1, 1, 0, 1, 0);
    add(1, 1, 0, 1,  1, 1, 1, 0, 0);
    add(1, 0, 0, 1,  1, 1, 0, 1, 0);
    add(1, 0, 0, 4,  1, 0, 0, 1, 0);
    add(1, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1, 7, 0, 1,  1, 0, 0, 1, 0);
    add(1, 7, 0, 4,  1, 1, 0, 1, 0);
    add(1, 7, 0, 4,  1, 2, 0, 1, 0);
    add(1, 7, 0, 4,  1, 3, 0, 1, 0);
    add(1, 7, 0, 4,  1, 4, 0, 1, 0);
    add(1, 7, 1, 1,  0, 0, 0, 0, 1);
    add(1, 7, 0, 3,  0, 0, 0, 0, 1);
    add(0, 7, 0, 1,  0, 0, 0, 0, 0);
    add(1, 7, 0, 1,  1, 0, 0, 1, 0);
    add(1, 7, 0, 28, 1, 7, 0, 1, 0);
    add(1, 7, 0, 1,  1, 7, 1, 0, 0);
    add(1, 7, 0, 8,  1, 7, 1, 0, 0);
    bus.enable_in = 1'b1;
    bus.target_in = 3'd7;
    bus.estop     = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_hold", 7'b0);
    rst_n = 1'b1;
    #1 check("reset_release_idle", 7'b0);
    @(negedge clk);
    check("first_edge_ramp", {1'b1, 3'd0, 1'b0, 1'b1, 1'b0});
    bus.enable_in = 1'b0;
    @(negedge clk);
    check("ramp_abort_idle", 7'b0);
    foreach (tbl[i]) begin
      bus.enable_in = tbl[i].en;
      bus.target_in = tbl[i].tgt;
      bus.estop     = tbl[i].es;
      repeat (tbl[i].n) @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    bus.target_in = 3'd2;
    @(negedge clk);
    check("hold7_retarget", {1'b1, 3'd7, 1'b0, 1'b1, 1'b0});
    repeat (4) @(negedge clk);
    check("down_to6", {1'b1, 3'd6, 1'b0, 1'b1, 1'b0});
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_midramp", 7'b0);
    bus.enable_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", 7'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
